loa_err_monitor: RTL and testbench
==================================

# loa_err_monitor

Streaming error-characterisation block for the lower-part-OR approximate adder. It consumes operand pairs over a valid/ready handshake and computes both the approximate and the exact sum of each pair. Over a window of 2^N_LOG accepted samples it accumulates error statistics: erroneous-sample count, summed error distance, maximum error distance and mean error distance. It sits on the consumer side of the approximate adder, in the characterisation/test harness, and reports results to a host register interface.

## Interface
- W, 4, operand width in bits.
- P, 3, approximated low bits, 0..W; P=0 gives an exact adder.
- N_LOG, 8, log2 of window length in samples, ≥1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears statistics and opens a new window.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- err_count  out  N_LOG+1  number of samples with non-zero error distance.
- err_sum  out  W+1+N_LOG  sum of error distances.
- err_max  out  W+1  largest error distance in the window.
- mean_ed  out  W+1  err_sum >> N_LOG.
- done  out  1  window complete; statistics are final.

## Operation
- Approximate sum Y has W+1 bits:
  - Y[i] = a[i] | b[i] for i < P.
  - Carry into bit P = a[P-1] & b[P-1] when P > 0; otherwise 0.
  - Bits P..W-1 use an exact ripple/CLA: Y[i] = a^b^c, c_next = g | (p & c).
  - Y[W] = final carry.
- Exact sum = a + b, W+1 bits. Error distance ED = |exact − Y|, W+1 bits, unsigned.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=0. start → RUN.
  - RUN: in_ready=1. A handshake (in_valid & in_ready) increments sample_cnt. Accepting sample number 2^N_LOG moves the FSM to DRAIN.
  - DRAIN: in_ready=0. Lasts one cycle while the last sample accumulates, then → DONE.
  - DONE: done=1, in_ready=0, statistics held. start → RUN.
- Pipeline:
  - Stage 1 registers a, b and s1_valid on each handshake.
  - Stage 2 computes ED from the stage-1 registers combinationally and, when s1_valid is set, updates at the clock edge: err_sum += ED; err_count += (ED≠0); err_max = max(err_max, ED).
- Entering RUN via start clears err_count, err_sum, err_max, sample_cnt and s1_valid in the same edge.
- start in RUN or DRAIN is ignored.
- Accumulator widths are sized for the worst case, so no saturation or overflow can occur.
- Reset value of every output and internal register is 0; the FSM resets to IDLE.

## Timing
- Handshake: a transfer occurs on a rising edge where in_valid=1 and in_ready=1. The producer must hold a and b stable while in_valid=1 and in_ready=0.
- in_ready is a registered function of state only; it does not depend combinationally on in_valid.
- Latency: a pair accepted at edge t enters stage 1 at t and is visible in the statistics after edge t+1.
- Throughput: one sample per cycle with no bubbles required.
- done rises after the edge following acceptance of the last sample, i.e. edge t+1 where t is the 2^N_LOG-th handshake. It stays high until the start edge.
- start in IDLE or DONE: in_ready=1 from the next cycle, and done falls on that same edge.
- rst at any point, including mid-RUN or in DRAIN, returns the block to IDLE with all statistics 0 on the next edge. A pending stage-1 sample is discarded.
- rst and start asserted together: rst wins.
- mean_ed is combinational from err_sum. It is meaningful only while done=1.

## Test plan
- Reset: assert rst for 2 cycles → in_ready=0, done=0, err_count=err_sum=err_max=mean_ed=0.
- W=4, P=3, N_LOG=2: start, then pairs (3,1), (7,7), (3,3), (4,4) back-to-back. ED values are 1, 1, 3, 4. Required result: done 1 cycle after the 4th handshake; err_count=4, err_sum=9, err_max=4, mean_ed=2.
- P=0, N_LOG=2, any 4 pairs, e.g. (15,15), (9,6): err_count=0, err_sum=0, err_max=0, done=1.
- Same stimulus as the P=3 case with in_valid deasserted for 1–3 random cycles between pairs: only handshakes count, identical totals (4/9/4/2), done timing relative to the last handshake unchanged.
- Reset mid-window: after 2 handshakes assert rst → IDLE, all outputs 0. Then start plus the 4-sample set → totals 4/9/4/2.
- start pulse during RUN after 1 sample is ignored (window still ends after 4 handshakes). start in DONE clears statistics to 0, raises in_ready next cycle and drops done.

Source files
------------

// File: rtl/loa_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : loa_err_monitor
// Description : Error-statistics monitor for the lower-part-OR approximate
//               adder over a window of 2^N_LOG handshaked operand pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module loa_err_monitor #(
    parameter int W     = 4,
    parameter int P     = 3,
    parameter int N_LOG = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [W-1:0]       a_i,
    input  logic [W-1:0]       b_i,
    output logic [N_LOG:0]     err_count_o,
    output logic [W+N_LOG:0]   err_sum_o,
    output logic [W:0]         err_max_o,
    output logic [W:0]         mean_ed_o,
    output logic               done_o
);

    localparam logic [N_LOG:0] c_LAST = (N_LOG+1)'((1 << N_LOG) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_LOG:0]     sample_cnt_q;
    logic [W-1:0]       a_q, b_q;
    logic               s1_valid_q;
    logic [N_LOG:0]     err_count_q;
    logic [W+N_LOG:0]   err_sum_q;
    logic [W:0]         err_max_q;

    logic               w_hs;
    logic               w_open;
    logic [W:0]         w_approx;
    logic [W:0]         w_exact;
    logic [W:0]         w_ed;

    assign w_hs   = in_valid_i & in_ready_o;
    // start is only honoured when no window is in flight
    assign w_open = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));

    // ------------------------------------------------------------------
    // Window control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (w_hs && (sample_cnt_q == c_LAST)) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (start_i) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready_o = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);

    // ------------------------------------------------------------------
    // Stage 2: approximate vs exact sum of the registered pair
    // ------------------------------------------------------------------
    always_comb begin
        logic c;
        w_approx = '0;
        c        = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i < P) begin
                w_approx[i] = a_q[i] | b_q[i];
            end else begin
                w_approx[i] = a_q[i] ^ b_q[i] ^ c;
                c           = (a_q[i] & b_q[i]) | ((a_q[i] ^ b_q[i]) & c);
            end
            // the top OR bit seeds the exact upper part
            if ((P > 0) && (i == P - 1)) begin
                c = a_q[i] & b_q[i];
            end
        end
        w_approx[W] = c;
    end

    assign w_exact = {1'b0, a_q} + {1'b0, b_q};
    assign w_ed    = (w_exact >= w_approx) ? (w_exact - w_approx)
                                           : (w_approx - w_exact);

    // ------------------------------------------------------------------
    // Stage 1 capture and statistics accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= '0;
            a_q          <= '0;
            b_q          <= '0;
            s1_valid_q   <= 1'b0;
            err_count_q  <= '0;
            err_sum_q    <= '0;
            err_max_q    <= '0;
        end else if (w_open) begin
            sample_cnt_q <= '0;
            s1_valid_q   <= 1'b0;
            err_count_q  <= '0;
            err_sum_q    <= '0;
            err_max_q    <= '0;
        end else begin
            if (w_hs) begin
                a_q          <= a_i;
                b_q          <= b_i;
                sample_cnt_q <= sample_cnt_q + 1'b1;
            end
            s1_valid_q <= w_hs;
            if (s1_valid_q) begin
                err_sum_q   <= err_sum_q + (W+N_LOG+1)'(w_ed);
                err_count_q <= err_count_q + (N_LOG+1)'(w_ed != '0);
                if (w_ed > err_max_q) begin
                    err_max_q <= w_ed;
                end
            end
        end
    end

    assign err_count_o = err_count_q;
    assign err_sum_o   = err_sum_q;
    assign err_max_o   = err_max_q;
    assign mean_ed_o   = err_sum_q[N_LOG +: W+1];

endmodule
`default_nettype wire

// File: tb/tb_loa_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_loa_err_monitor
// Description : Directed table-driven bench for loa_err_monitor (P=3 and P=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loa_err_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;

    logic       rdy3, done3, rdy0, done0;
    logic [2:0] cnt3, cnt0;
    logic [6:0] sum3, sum0;
    logic [4:0] max3, max0, mean3, mean0;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    loa_err_monitor #(.W(4), .P(3), .N_LOG(2)) dut (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(rdy3), .a_i(a), .b_i(b), .err_count_o(cnt3),
        .err_sum_o(sum3), .err_max_o(max3), .mean_ed_o(mean3), .done_o(done3)
    );

    loa_err_monitor #(.W(4), .P(0), .N_LOG(2)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(rdy0), .a_i(a), .b_i(b), .err_count_o(cnt0),
        .err_sum_o(sum0), .err_max_o(max0), .mean_ed_o(mean0), .done_o(done0)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         gap;
        logic [4:0] ed;   // hand-computed error distance for P=3
    } vec_t;

    vec_t tv[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] aa, input logic [3:0] bb, input int gap, input logic st);
        int w;
        in_valid = 1'b0;
        repeat (gap) tick();
        a = aa;
        b = bb;
        in_valid = 1'b1;
        start = st;
        w = 0;
        while (!rdy3 && w < 20) begin
            tick();
            w++;
        end
        if (!rdy3) check("ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_cnt3"}, 32'(cnt3), 0);
        check({nm, "_sum3"}, 32'(sum3), 0);
        check({nm, "_max3"}, 32'(max3), 0);
        check({nm, "_sum0"}, 32'(sum0), 0);
        check({nm, "_done"}, 32'(done3), 0);
    endtask

    task automatic pulse_start(input string nm);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({nm, "_ready"}, 32'(rdy3), 1);
        check({nm, "_ready0"}, 32'(rdy0), 1);
        check_zero(nm);
    endtask

    // After the last handshake: one DRAIN cycle, then DONE with final totals.
    task automatic check_end(input string nm, input int ec, input int es, input int em);
        check({nm, "_drain_done"}, 32'(done3), 0);
        check({nm, "_drain_ready"}, 32'(rdy3), 0);
        tick();
        check({nm, "_done3"}, 32'(done3), 1);
        check({nm, "_done0"}, 32'(done0), 1);
        check({nm, "_cnt3"}, 32'(cnt3), 32'(ec));
        check({nm, "_sum3"}, 32'(sum3), 32'(es));
        check({nm, "_max3"}, 32'(max3), 32'(em));
        check({nm, "_mean3"}, 32'(mean3), 32'(es >> 2));
        check({nm, "_cnt0"}, 32'(cnt0), 0);
        check({nm, "_sum0"}, 32'(sum0), 0);
        check({nm, "_max0"}, 32'(max0), 0);
        check({nm, "_mean0"}, 32'(mean0), 0);
    endtask

    task automatic run_window(input string nm, input int base, input logic st_mid);
        int ec, es, em;
        ec = 0; es = 0; em = 0;
        pulse_start(nm);
        for (int k = 0; k < 4; k++) begin
            send(tv[base+k].a, tv[base+k].b, tv[base+k].gap, (k == 1) ? st_mid : 1'b0);
            if (tv[base+k].ed != 0) ec++;
            es += int'(tv[base+k].ed);
            if (int'(tv[base+k].ed) > em) em = int'(tv[base+k].ed);
        end
        check_end(nm, ec, es, em);
    endtask

    initial begin
        // Window A: back-to-back, EDs 1,1,3,4
        tv[0]  = '{4'd3,  4'd1, 0, 5'd1};
        tv[1]  = '{4'd7,  4'd7, 0, 5'd1};
        tv[2]  = '{4'd3,  4'd3, 0, 5'd3};
        tv[3]  = '{4'd4,  4'd4, 0, 5'd4};
        // Window B: same pairs with idle gaps
        tv[4]  = '{4'd3,  4'd1, 1, 5'd1};
        tv[5]  = '{4'd7,  4'd7, 3, 5'd1};
        tv[6]  = '{4'd3,  4'd3, 2, 5'd3};
        tv[7]  = '{4'd4,  4'd4, 1, 5'd4};
        // Window C: mostly error-free pairs
        tv[8]  = '{4'd15, 4'd15, 0, 5'd1};
        tv[9]  = '{4'd9,  4'd6, 0, 5'd0};
        tv[10] = '{4'd0,  4'd0, 0, 5'd0};
        tv[11] = '{4'd5,  4'd2, 0, 5'd0};

        repeat (2) tick();
        rst = 1'b0;
        check("rst_ready", 32'(rdy3), 0);
        check("rst_mean", 32'(mean3), 0);
        check_zero("rst");
        tick();
        check("idle_ready", 32'(rdy3), 0);

        run_window("winA", 0, 1'b0);
        check("winA_const_sum", 32'(sum3), 9);
        check("winA_const_mean", 32'(mean3), 2);
        repeat (3) tick();
        check("done_held", 32'(done3), 1);
        check("done_held_sum", 32'(sum3), 9);

        run_window("winB", 4, 1'b0);
        run_window("winC", 8, 1'b0);
        // start asserted alongside the second handshake must be ignored
        run_window("startrun", 0, 1'b1);

        // Reset mid-window discards accumulated and pending samples
        pulse_start("mid");
        send(tv[0].a, tv[0].b, 0, 1'b0);
        send(tv[1].a, tv[1].b, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(rdy3), 0);
        check_zero("midrst");
        tick();
        check_zero("midrst_hold");
        run_window("afterrst", 0, 1'b0);

        // rst dominates a simultaneous start
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rststart_ready", 32'(rdy3), 0);
        check_zero("rststart");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
